// File: rtl/wb_slave_mem.sv
`timescale 1ns/1ps
// Wishbone classic-cycle slave memory: windowed address decode, fixed wait states,
// byte-lane-masked writes, error termination for out-of-window accesses.
module wb_slave_mem #(
    parameter int                    DATA_WIDTH  = 16,
    parameter int                    ADDR_WIDTH  = 32,
    parameter int                    DEPTH       = 256,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = '0,
    parameter int                    WAIT_STATES = 1
) (
    input  logic                    clk_i,
    input  logic                    rst_n_i,
    input  logic                    cyc_i,
    input  logic                    stb_i,
    input  logic                    we_i,
    input  logic [ADDR_WIDTH-1:0]   adr_i,
    input  logic [DATA_WIDTH-1:0]   dat_i,
    input  logic [DATA_WIDTH/8-1:0] sel_i,
    output logic [DATA_WIDTH-1:0]   dat_o,
    output logic                    ack_o,
    output logic                    err_o,
    output logic [15:0]             rd_cnt_o,
    output logic [15:0]             wr_cnt_o
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int LANES = DATA_WIDTH / 8;
    localparam logic [ADDR_WIDTH:0] WIN_LO = {1'b0, BASE_ADDR};
    localparam logic [ADDR_WIDTH:0] WIN_HI = WIN_LO + (ADDR_WIDTH+1)'(2 * DEPTH);
    localparam logic [3:0] WCNT_INIT = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

    typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} state_t;

    state_t                  state_q, state_d;
    logic [3:0]              wcnt_q, wcnt_d;
    logic                    we_q, we_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [DATA_WIDTH-1:0]   wdat_q, wdat_d;
    logic [LANES-1:0]        sel_q, sel_d;
    logic                    hit_q, hit_d;
    logic                    ack_q, ack_d;
    logic                    err_q, err_d;
    logic [DATA_WIDTH-1:0]   rdat_q, rdat_d;
    logic [15:0]             rd_cnt_q, rd_cnt_d;
    logic [15:0]             wr_cnt_q, wr_cnt_d;
    logic                    fire;
    logic                    mem_we;
    logic                    hit_now;

    logic [DATA_WIDTH-1:0]   mem [DEPTH];

    // Wide compare so the upper window bound cannot overflow at the top of the address space.
    assign hit_now = ({1'b0, adr_i} >= WIN_LO) && ({1'b0, adr_i} < WIN_HI);

    always_comb begin
        state_d  = state_q;
        wcnt_d   = wcnt_q;
        we_d     = we_q;
        idx_d    = idx_q;
        wdat_d   = wdat_q;
        sel_d    = sel_q;
        hit_d    = hit_q;
        ack_d    = 1'b0;
        err_d    = 1'b0;
        rdat_d   = rdat_q;
        rd_cnt_d = rd_cnt_q;
        wr_cnt_d = wr_cnt_q;
        fire     = 1'b0;
        mem_we   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (cyc_i && stb_i) begin
                    we_d   = we_i;
                    idx_d  = adr_i[IDX_W:1];
                    wdat_d = dat_i;
                    sel_d  = sel_i;
                    hit_d  = hit_now;
                    if (WAIT_STATES == 0) begin
                        state_d = ST_RESP;
                        fire    = 1'b1;
                    end else begin
                        state_d = ST_WAIT;
                        wcnt_d  = WCNT_INIT;
                    end
                end
            end
            ST_WAIT: begin
                if (!cyc_i) begin
                    state_d = ST_IDLE;
                end else if (wcnt_q == 4'd0) begin
                    state_d = ST_RESP;
                    fire    = 1'b1;
                end else begin
                    wcnt_d = wcnt_q - 4'd1;
                end
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        // Terminate on the edge that enters RESP; the read sees pre-write contents.
        if (fire) begin
            if (hit_d) begin
                ack_d = 1'b1;
                if (we_d) begin
                    mem_we   = 1'b1;
                    wr_cnt_d = wr_cnt_q + 16'd1;
                end else begin
                    rdat_d   = mem[idx_d];
                    rd_cnt_d = rd_cnt_q + 16'd1;
                end
            end else begin
                err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (mem_we) begin
            for (int i = 0; i < LANES; i++) begin
                if (sel_d[i]) begin
                    mem[idx_d][i*8 +: 8] <= wdat_d[i*8 +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q  <= ST_IDLE;
            wcnt_q   <= '0;
            we_q     <= 1'b0;
            idx_q    <= '0;
            wdat_q   <= '0;
            sel_q    <= '0;
            hit_q    <= 1'b0;
            ack_q    <= 1'b0;
            err_q    <= 1'b0;
            rdat_q   <= '0;
            rd_cnt_q <= '0;
            wr_cnt_q <= '0;
        end else begin
            state_q  <= state_d;
            wcnt_q   <= wcnt_d;
            we_q     <= we_d;
            idx_q    <= idx_d;
            wdat_q   <= wdat_d;
            sel_q    <= sel_d;
            hit_q    <= hit_d;
            ack_q    <= ack_d;
            err_q    <= err_d;
            rdat_q   <= rdat_d;
            rd_cnt_q <= rd_cnt_d;
            wr_cnt_q <= wr_cnt_d;
        end
    end

    assign dat_o    = rdat_q;
    assign ack_o    = ack_q;
    assign err_o    = err_q;
    assign rd_cnt_o = rd_cnt_q;
    assign wr_cnt_o = wr_cnt_q;

endmodule

// File: doc/wb_slave_mem.md
# wb_slave_mem

Wishbone classic-cycle slave memory that sits directly downstream of the ahb2wb bridge and terminates its Wishbone master port. It decodes a 32-bit byte address against a configurable window, inserts a fixed number of wait states, performs byte-lane-masked 16-bit writes and full-word reads, and signals `err_o` for out-of-window accesses. Read and write completion counters are exposed for bench scoreboarding and coverage.

## Interface
- `DATA_WIDTH`, 16: Wishbone data width. Only 16 is supported.
- `ADDR_WIDTH`, 32: Wishbone byte-address width.
- `DEPTH`, 256: number of 16-bit words. Must be a power of two, at least 2.
- `BASE_ADDR`, 32'h0000_0000: byte address of word 0. Must be 2×DEPTH aligned.
- `WAIT_STATES`, 1: wait cycles inserted before `ack_o`/`err_o`. Range 0..15.

Ports:
- `clk_i`  in  1  Wishbone clock; all logic on the rising edge.
- `rst_n_i`  in  1  Reset; asynchronous assert, active-low.
- `cyc_i`  in  1  Bus cycle valid.
- `stb_i`  in  1  Strobe.
- `we_i`  in  1  1 = write, 0 = read.
- `adr_i`  in  32  Byte address. Bit 0 is ignored.
- `dat_i`  in  16  Write data.
- `sel_i`  in  2  Byte lanes. `sel_i[0]` selects bits 7:0, `sel_i[1]` selects bits 15:8.
- `dat_o`  out  16  Read data. Valid while `ack_o` is high for a read.
- `ack_o`  out  1  Normal termination, one-cycle pulse.
- `err_o`  out  1  Error termination, one-cycle pulse.
- `rd_cnt_o`  out  16  Count of acked reads. Wraps.
- `wr_cnt_o`  out  16  Count of acked writes. Wraps.

## Operation
- Address decode:
  - `hit` = (`adr_i` ≥ `BASE_ADDR`) and (`adr_i` < `BASE_ADDR` + 2×DEPTH).
  - Word index = `adr_i[log2(DEPTH):1]`.
- FSM states IDLE, WAIT, RESP. Reset state is IDLE.
- IDLE:
  - On `cyc_i & stb_i`, latch `we_i`, `adr_i`, `dat_i`, `sel_i` and `hit`.
  - If `WAIT_STATES` = 0, go to RESP; otherwise go to WAIT with the wait counter set to `WAIT_STATES`−1.
- WAIT:
  - If `cyc_i` = 0, abort: go to IDLE with no memory access, no termination and no count change.
  - If the counter is 0, go to RESP; otherwise decrement the counter.
- Entering RESP, with `cyc_i` still high on the transition edge (or `WAIT_STATES` = 0):
  - Hit: `ack_o` = 1.
    - Write: update only the lanes set in the latched `sel`; `sel` = 2'b00 writes nothing but still acks.
    - Read: `dat_o` = mem[index] from the pre-write contents, using all lanes regardless of `sel`.
    - Increment the matching counter, wrapping 16'hFFFF → 0.
  - Miss: `err_o` = 1. Memory, `dat_o` and both counters are unchanged.
- RESP → IDLE unconditionally. `stb_i` sampled on the RESP-exit edge is ignored, because the master sees ack on that same edge.
- `dat_o` holds its last read value between reads.
- `ack_o` and `err_o` are never high together.
- Memory contents are not reset; reading an unwritten location returns an undefined value.

## Timing
- Reset, asynchronous while `rst_n_i` = 0:
  - `ack_o`, `err_o`, `dat_o`, `rd_cnt_o` and `wr_cnt_o` are 0.
  - FSM is in IDLE; any in-flight transfer is dropped with no write.
- Request sampled at edge N → `ack_o`/`err_o` high for exactly the cycle after edge N+`WAIT_STATES`.
- Write data is visible to a read issued in the next transaction.
- Back-to-back throughput: one transfer per `WAIT_STATES`+2 cycles, since RESP is followed by one IDLE sample.
- All outputs are registered. There are no combinational paths from inputs to outputs.
- Deasserting `stb_i` alone during WAIT does not abort; only `cyc_i` = 0 aborts.

## Test plan
- `WAIT_STATES`=1, `BASE_ADDR`=0: write 16'hA5C3 to 0x10 with `sel`=2'b11, then read 0x10.
  - Required: each ack arrives 2 cycles after the strobe edge; read returns 16'hA5C3; `wr_cnt_o`=1, `rd_cnt_o`=1.
- Byte lanes: write 16'h1234 to 0x20, then write 16'hFFFF with `sel`=2'b01, then read 0x20.
  - Required: read returns 16'h12FF. A further write with `sel`=2'b00 leaves 16'h12FF but still acks.
- Address window: read 0x200 with `DEPTH`=256.
  - Required: `err_o` pulses once, `ack_o` stays 0, counters and `dat_o` unchanged.
  - Boundary: read 0x1FE acks normally; `adr_i` 0x11 aliases word 8.
- Abort: start a write to 0x30 with `WAIT_STATES`=3, drop `cyc_i` one cycle later, then read 0x30.
  - Required: no termination for the aborted write; the read returns the old data; `wr_cnt_o` unchanged.
- Reset mid-transfer: assert `rst_n_i` during WAIT.
  - Required: outputs clear immediately without waiting for a clock; after release the next access completes normally.
- Counter wrap: preload with 65535 reads, then issue one more read.
  - Required: `rd_cnt_o` goes 16'hFFFF → 16'h0000.
  - `WAIT_STATES`=0 back-to-back reads: ack every 2nd cycle.
